// File: rtl/coin_credit_ctrl.sv
// -----------------------------------------------------------------------------
// coin_credit_ctrl
//
// Vending-machine credit controller. Coins are added to a credit register
// through a carry-out add, and a coin is refused if the addition would wrap or
// go past MAX_CREDIT. In IDLE the controller arbitrates cancel > vend_req >
// coin. A small FSM (IDLE / DISPENSE / CHANGE) sequences product release and
// the change-return handshake.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   coin_valid, coin_value      coin presented by the acceptor front end
//   coin_ready                  controller takes a coin this cycle (comb.)
//   coin_accept, coin_reject    one-cycle result pulses, 1 cycle after a coin
//   vend_req, price             purchase request, sampled in IDLE
//   cancel                      return all credit
//   dispense                    one-cycle product release pulse
//   vend_deny                   one-cycle pulse: credit below price
//   change_valid, change_amt    change presented to the change dispenser
//   change_ready                change dispenser takes change_amt
//   credit                      current registered credit
//   busy                        FSM is not in IDLE
//   ovf_sticky                  (optional) set on any coin reject
//
// Optional feature: define COIN_CREDIT_OVF_STICKY_EN to add the ovf_sticky
// output. It is cleared only by rst or by a completed change handshake.
// -----------------------------------------------------------------------------
module coin_credit_ctrl #(
   parameter int WIDTH      = 5,
   parameter int MAX_CREDIT = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             coin_valid,
   input  logic [WIDTH-1:0] coin_value,
   output logic             coin_ready,
   output logic             coin_accept,
   output logic             coin_reject,
   input  logic             vend_req,
   input  logic [WIDTH-1:0] price,
   input  logic             cancel,
   output logic             dispense,
   output logic             vend_deny,
   output logic             change_valid,
   output logic [WIDTH-1:0] change_amt,
   input  logic             change_ready,
   output logic [WIDTH-1:0] credit,
   output logic             busy
`ifdef COIN_CREDIT_OVF_STICKY_EN
   ,
   output logic             ovf_sticky
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DISPENSE,
      S_CHANGE
   } state_t;

   localparam logic [WIDTH:0] MAX_SUM = (WIDTH+1)'(MAX_CREDIT);

   state_t           state;
   logic [WIDTH-1:0] remainder_q;   // credit - price, latched when a vend is granted
   logic [WIDTH:0]   sum;
   logic             overflow;

   // One extra bit keeps the carry so a wrapped sum is never mistaken for a
   // small legal credit.
   assign sum      = {1'b0, credit} + {1'b0, coin_value};
   assign overflow = sum[WIDTH] | (sum > MAX_SUM);

   assign coin_ready = (state == S_IDLE) & ~cancel & ~vend_req;
   assign busy       = (state != S_IDLE);

   // NOTE: every register here is written with <= so all updates in a cycle see
   // the pre-edge values; blocking assignments would make results order-dependent.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         credit       <= '0;
         remainder_q  <= '0;
         coin_accept  <= 1'b0;
         coin_reject  <= 1'b0;
         dispense     <= 1'b0;
         vend_deny    <= 1'b0;
         change_valid <= 1'b0;
         change_amt   <= '0;
`ifdef COIN_CREDIT_OVF_STICKY_EN
         ovf_sticky   <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low and are raised for exactly one cycle.
         coin_accept <= 1'b0;
         coin_reject <= 1'b0;
         dispense    <= 1'b0;
         vend_deny   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (cancel) begin
                  // Nothing to refund means nothing to do.
                  if (credit != '0) begin
                     change_amt <= credit;
                     state      <= S_CHANGE;
                  end
               end else if (vend_req) begin
                  if (credit >= price) begin
                     // Latch the remainder so a later change on price cannot
                     // corrupt the amount debited in DISPENSE.
                     remainder_q <= credit - price;
                     state       <= S_DISPENSE;
                  end else begin
                     vend_deny <= 1'b1;
                  end
               end else if (coin_valid && coin_ready) begin
                  if (overflow) begin
                     coin_reject <= 1'b1;
`ifdef COIN_CREDIT_OVF_STICKY_EN
                     ovf_sticky  <= 1'b1;
`endif
                  end else begin
                     credit      <= sum[WIDTH-1:0];
                     coin_accept <= 1'b1;
                  end
               end
            end

            S_DISPENSE: begin
               dispense <= 1'b1;
               credit   <= remainder_q;
               if (remainder_q != '0) begin
                  change_amt <= remainder_q;
                  state      <= S_CHANGE;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_CHANGE: begin
               // change_valid rises on the cycle after entry, which places it
               // one cycle behind the dispense pulse on the vend path.
               if (!change_valid) begin
                  change_valid <= 1'b1;
               end else if (change_ready) begin
                  credit       <= '0;
                  change_valid <= 1'b0;
                  change_amt   <= '0;
                  state        <= S_IDLE;
`ifdef COIN_CREDIT_OVF_STICKY_EN
                  ovf_sticky   <= 1'b0;
`endif
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/coin_credit_ctrl.md
Name: coin_credit_ctrl

Overview:
Vending-machine credit controller. Accumulates inserted coin values into a 5-bit credit register through a carry-out add, and rejects any coin whose addition would overflow. It also arbitrates between cancel, vend and coin-insert requests, and sequences dispense and change return through a small FSM. It sits between the coin acceptor front end and the product and change dispensers.

Parameters:
WIDTH, 5, credit/coin/price datapath width in bits
MAX_CREDIT, 31, highest legal credit; must be ≤ 2^WIDTH-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
coin_valid  input  1  coin present this cycle
coin_value  input  WIDTH  value of the presented coin
coin_ready  output  1  controller can take a coin this cycle
coin_accept  output  1  one-cycle pulse: coin added to credit
coin_reject  output  1  one-cycle pulse: coin refused (overflow/limit)
vend_req  input  1  purchase request (level, sampled when in IDLE)
price  input  WIDTH  price of requested item, sampled with vend_req
cancel  input  1  return all credit
dispense  output  1  one-cycle pulse: release product
vend_deny  output  1  one-cycle pulse: insufficient credit
change_valid  output  1  change amount presented
change_amt  output  WIDTH  change to return; valid while change_valid
change_ready  input  1  change dispenser takes change_amt
credit  output  WIDTH  current registered credit
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE, credit=0. All pulses, change_valid and change_amt are 0. Reset has priority over every input and aborts any state, including CHANGE mid-handshake.
- States: IDLE, DISPENSE, CHANGE.
- coin_ready = (state==IDLE) & ~cancel & ~vend_req, combinational. Priority in IDLE: cancel > vend_req > coin.
- Coin add: sum = {1'b0,credit} + {1'b0,coin_value}, WIDTH+1 bits wide. Overflow = sum[WIDTH] | (sum > MAX_CREDIT).
- Coin handshake on coin_valid & coin_ready:
  - No overflow: credit <= sum[WIDTH-1:0] and coin_accept=1 in the next cycle.
  - Overflow: credit unchanged and coin_reject=1 in the next cycle.
  - coin_value==0 is accepted with credit unchanged.
- Coins presented while coin_ready=0 are ignored: no pulse, and no state change.
- IDLE & cancel:
  - credit>0: go to CHANGE with change_amt=credit.
  - credit==0: no action.
- IDLE & vend_req (no cancel):
  - credit ≥ price: go to DISPENSE and latch credit-price internally.
  - credit < price: vend_deny pulse next cycle, stay in IDLE, credit unchanged.
  - price==0 always dispenses.
- DISPENSE (exactly 1 cycle): dispense=1 and credit <= credit-price.
  - Remainder >0: next state CHANGE, change_amt=remainder.
  - Remainder ==0: next state IDLE.
- CHANGE: change_valid=1 and change_amt is held stable until change_ready.
  - On change_valid & change_ready: credit <= 0, change_valid <= 0, go to IDLE.
  - change_ready is waited on indefinitely; cancel, vend_req and coins are ignored while in CHANGE.
- Latency: coin→accept/reject 1 cycle; vend_req→dispense 2 cycles; dispense→change_valid 1 cycle.
- credit output is the register value. It never exceeds MAX_CREDIT and never wraps.

Optional Feature:
Macro COIN_CREDIT_OVF_STICKY_EN.
- Defined: adds output ovf_sticky (1 bit), set on any coin_reject and cleared only by rst or by completion of a CHANGE handshake. Gives service diagnostics.
- Undefined: the port and register are absent, and all other behaviour is identical.

Test Plan:
1. Reset, then coins 10 and 5 → coin_accept pulses on the cycle after each coin, credit=15, busy=0.
2. credit=28, coin 5 (sum 33, carry out) → coin_reject pulse, credit stays 28. With the macro defined, ovf_sticky=1.
3. credit=20, vend_req with price=15 → dispense pulse 2 cycles later, then change_valid with change_amt=5. Hold change_ready=0 for 3 cycles: change_amt stays 5. Raise change_ready → credit=0, IDLE.
4. credit=10, vend_req with price=12 → vend_deny pulse, credit 10, no dispense. Then price=10 → dispense, no CHANGE, credit=0.
5. credit=7: assert cancel, vend_req and coin_valid(5) in the same cycle → coin_ready=0, no accept. Controller enters CHANGE with change_amt=7 (cancel wins).
6. Assert rst while in CHANGE with change_amt=9 → the next cycle shows IDLE, credit=0, change_valid=0 and all pulses 0.
